// File: rtl/grf_wport_arbiter.sv
//==============================================================================
// Module : grf_wport_arbiter
// Shares the GRF write port between WB (priority) and a 2-entry AUX FIFO.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module grf_wport_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [31:0] i_wb_pc,
    output logic        o_wb_stall,
    input  logic        i_aux_valid,
    output logic        o_aux_ready,
    input  logic [4:0]  i_aux_addr,
    input  logic [31:0] i_aux_data,
    input  logic [31:0] i_aux_pc,
    output logic [4:0]  o_grf_waddr,
    output logic [31:0] o_grf_wdata,
    output logic [31:0] o_grf_wpc,
    input  logic [4:0]  i_q0_addr,
    input  logic [4:0]  i_q1_addr,
    output logic        o_q0_pending,
    output logic        o_q1_pending,
    output logic [1:0]  o_pending_cnt
);

    localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(STARVE_LIMIT);

    // Entry 0 is always the head; entry 1 is valid only when entry 0 is.
    logic             r_init;
    logic [1:0]       r_vld;
    logic [4:0]       r_addr [2];
    logic [31:0]      r_data [2];
    logic [31:0]      r_pc   [2];
    logic [CNT_W-1:0] r_cnt;

    logic             w_force;
    logic             w_wb_act;
    logic             w_drain;
    logic             w_accept;
    logic             w_push;
    logic [1:0]       w_keep;
    logic [1:0]       w_n_vld;
    logic [4:0]       w_n_addr [2];
    logic [31:0]      w_n_data [2];
    logic [31:0]      w_n_pc   [2];
    logic [CNT_W-1:0] w_n_cnt;

    assign w_force  = r_init && r_vld[0] && (r_cnt >= c_LIMIT);
    assign w_wb_act = r_init && i_wb_valid && (i_wb_addr != 5'd0);
    assign w_drain  = r_init && !w_force && !w_wb_act && r_vld[0];
    assign w_accept = i_aux_valid && o_aux_ready;
    assign w_push   = w_accept && (i_aux_addr != 5'd0)
                      && !(w_wb_act && !w_force && (i_aux_addr == i_wb_addr));

    assign o_aux_ready   = r_init && !(r_vld[0] && r_vld[1]);
    assign o_pending_cnt = {1'b0, r_vld[0]} + {1'b0, r_vld[1]};
    assign o_wb_stall    = w_force;

    assign o_q0_pending = (i_q0_addr != 5'd0) &&
                          ((r_vld[0] && (r_addr[0] == i_q0_addr)) ||
                           (r_vld[1] && (r_addr[1] == i_q0_addr)));
    assign o_q1_pending = (i_q1_addr != 5'd0) &&
                          ((r_vld[0] && (r_addr[0] == i_q1_addr)) ||
                           (r_vld[1] && (r_addr[1] == i_q1_addr)));

    always_comb begin
        o_grf_waddr = 5'd0;
        o_grf_wdata = 32'd0;
        o_grf_wpc   = 32'd0;
        if (w_force || w_drain) begin
            o_grf_waddr = r_addr[0];
            o_grf_wdata = r_data[0];
            o_grf_wpc   = r_pc[0];
        end else if (w_wb_act) begin
            o_grf_waddr = i_wb_addr;
            o_grf_wdata = i_wb_data;
            o_grf_wpc   = i_wb_pc;
        end
    end

    // A WB write to the same register supersedes any older queued result.
    always_comb begin
        w_keep = r_vld;
        if (w_force || w_drain) begin
            w_keep[0] = 1'b0;
        end else if (w_wb_act) begin
            w_keep[0] = r_vld[0] && (r_addr[0] != i_wb_addr);
            w_keep[1] = r_vld[1] && (r_addr[1] != i_wb_addr);
        end
    end

    // Compact survivors towards the head, then append the new entry.
    always_comb begin
        w_n_vld     = 2'b00;
        w_n_addr[0] = r_addr[0];
        w_n_data[0] = r_data[0];
        w_n_pc[0]   = r_pc[0];
        w_n_addr[1] = r_addr[1];
        w_n_data[1] = r_data[1];
        w_n_pc[1]   = r_pc[1];
        if (w_keep[0]) begin
            w_n_vld[0] = 1'b1;
            if (w_keep[1]) begin
                w_n_vld[1] = 1'b1;
            end else if (w_push) begin
                w_n_vld[1]  = 1'b1;
                w_n_addr[1] = i_aux_addr;
                w_n_data[1] = i_aux_data;
                w_n_pc[1]   = i_aux_pc;
            end
        end else if (w_keep[1]) begin
            w_n_vld[0]  = 1'b1;
            w_n_addr[0] = r_addr[1];
            w_n_data[0] = r_data[1];
            w_n_pc[0]   = r_pc[1];
            if (w_push) begin
                w_n_vld[1]  = 1'b1;
                w_n_addr[1] = i_aux_addr;
                w_n_data[1] = i_aux_data;
                w_n_pc[1]   = i_aux_pc;
            end
        end else if (w_push) begin
            w_n_vld[0]  = 1'b1;
            w_n_addr[0] = i_aux_addr;
            w_n_data[0] = i_aux_data;
            w_n_pc[0]   = i_aux_pc;
        end
    end

    always_comb begin
        w_n_cnt = '0;
        if (w_wb_act && !w_force && (w_keep != 2'b00)) begin
            w_n_cnt = (r_cnt < c_LIMIT) ? r_cnt + 1'b1 : r_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init    <= 1'b0;
            r_vld     <= 2'b00;
            r_cnt     <= '0;
            r_addr[0] <= 5'd0;
            r_addr[1] <= 5'd0;
            r_data[0] <= 32'd0;
            r_data[1] <= 32'd0;
            r_pc[0]   <= 32'd0;
            r_pc[1]   <= 32'd0;
        end else if (!r_init) begin
            r_init <= 1'b1;
        end else begin
            r_vld     <= w_n_vld;
            r_cnt     <= w_n_cnt;
            r_addr[0] <= w_n_addr[0];
            r_addr[1] <= w_n_addr[1];
            r_data[0] <= w_n_data[0];
            r_data[1] <= w_n_data[1];
            r_pc[0]   <= w_n_pc[0];
            r_pc[1]   <= w_n_pc[1];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_grf_wport_arbiter.sv
//==============================================================================
// Module : tb_grf_wport_arbiter
// Directed bench for grf_wport_arbiter with a queue-based reference model.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_grf_wport_arbiter;

    localparam int c_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] wb_pc = '0;
    logic        aux_valid = 1'b0;
    logic [4:0]  aux_addr = '0;
    logic [31:0] aux_data = '0;
    logic [31:0] aux_pc = '0;
    logic [4:0]  q0_addr = '0;
    logic [4:0]  q1_addr = '0;
    logic        wb_stall, aux_ready, q0_pending, q1_pending;
    logic [4:0]  grf_waddr;
    logic [31:0] grf_wdata, grf_wpc;
    logic [1:0]  pending_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    grf_wport_arbiter #(.STARVE_LIMIT(c_LIMIT), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_wb_valid(wb_valid), .i_wb_addr(wb_addr), .i_wb_data(wb_data), .i_wb_pc(wb_pc),
        .o_wb_stall(wb_stall),
        .i_aux_valid(aux_valid), .o_aux_ready(aux_ready),
        .i_aux_addr(aux_addr), .i_aux_data(aux_data), .i_aux_pc(aux_pc),
        .o_grf_waddr(grf_waddr), .o_grf_wdata(grf_wdata), .o_grf_wpc(grf_wpc),
        .i_q0_addr(q0_addr), .i_q1_addr(q1_addr),
        .o_q0_pending(q0_pending), .o_q1_pending(q1_pending),
        .o_pending_cnt(pending_cnt)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] p;
    } ent_t;

    ent_t mq[$];
    int   m_cnt = 0;
    bit   m_init = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
        end
    endtask

    function automatic bit m_pend(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].a == q) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_force();
        return m_init && mq.size() > 0 && m_cnt >= c_LIMIT;
    endfunction

    function automatic bit m_wbact();
        return m_init && wb_valid && wb_addr != 5'd0;
    endfunction

    task automatic m_step();
        bit f, w, acc;
        f   = m_force();
        w   = m_wbact();
        acc = aux_valid && mq.size() < 2;
        if (f) begin
            void'(mq.pop_front());
            m_cnt = 0;
        end else if (w) begin
            for (int i = mq.size() - 1; i >= 0; i--)
                if (mq[i].a == wb_addr) mq.delete(i);
            m_cnt = (mq.size() > 0) ? ((m_cnt + 1 > c_LIMIT) ? c_LIMIT : m_cnt + 1) : 0;
        end else begin
            if (mq.size() > 0) void'(mq.pop_front());
            m_cnt = 0;
        end
        if (acc && aux_addr != 5'd0 && !(w && !f && aux_addr == wb_addr))
            mq.push_back('{a: aux_addr, d: aux_data, p: aux_pc});
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_cnt  = 0;
            m_init = 1'b0;
        end else if (!m_init) begin
            m_init = 1'b1;
        end else begin
            m_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [4:0]  e_a;
        logic [31:0] e_d, e_p;
        e_a = '0; e_d = '0; e_p = '0;
        if (m_force() || (m_init && !m_wbact() && mq.size() > 0)) begin
            e_a = mq[0].a; e_d = mq[0].d; e_p = mq[0].p;
        end else if (m_wbact()) begin
            e_a = wb_addr; e_d = wb_data; e_p = wb_pc;
        end
        chk("m_stall", 32'(wb_stall), 32'(m_force()));
        chk("m_ready", 32'(aux_ready), 32'(m_init && mq.size() < 2));
        chk("m_waddr", 32'(grf_waddr), 32'(e_a));
        chk("m_wdata", grf_wdata, e_d);
        chk("m_wpc", grf_wpc, e_p);
        chk("m_q0", 32'(q0_pending), 32'(m_pend(q0_addr)));
        chk("m_q1", 32'(q1_pending), 32'(m_pend(q1_addr)));
        chk("m_cnt", 32'(pending_cnt), 32'(mq.size()));
    end

    // ---------------- stimulus ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
        wb_valid = v; wb_addr = a; wb_data = d; wb_pc = 32'h1000 + {27'd0, a};
    endtask

    task automatic set_aux(input logic v, input logic [4:0] a, input logic [31:0] d);
        aux_valid = v; aux_addr = a; aux_data = d; aux_pc = 32'h2000 + {27'd0, a};
    endtask

    initial begin
        #2;
        chk("rst_ready", 32'(aux_ready), 32'd0);
        chk("rst_waddr", 32'(grf_waddr), 32'd0);
        next();
        next();
        rst_n = 1'b1;
        next();

        // Idle after reset
        #3;
        chk("idle_ready", 32'(aux_ready), 32'd1);
        chk("idle_waddr", 32'(grf_waddr), 32'd0);
        chk("idle_pcnt", 32'(pending_cnt), 32'd0);
        next();

        // Single push drains next cycle
        set_aux(1, 5, 32'hAAAA0005); q0_addr = 5;
        #3;
        chk("push_q0", 32'(q0_pending), 32'd0);
        chk("push_waddr", 32'(grf_waddr), 32'd0);
        next();
        set_aux(0, 0, 0);
        #3;
        chk("drain_waddr", 32'(grf_waddr), 32'd5);
        chk("drain_wdata", grf_wdata, 32'hAAAA0005);
        chk("drain_pcnt", 32'(pending_cnt), 32'd1);
        chk("drain_q0", 32'(q0_pending), 32'd1);
        next();
        #3;
        chk("after_q0", 32'(q0_pending), 32'd0);
        chk("after_pcnt", 32'(pending_cnt), 32'd0);
        next();

        // WB kills matching queued entry
        set_aux(1, 7, 32'h7777);
        next();
        set_wb(1, 1, 32'h1111); set_aux(1, 9, 32'h9999);
        next();
        set_wb(1, 9, 32'hB009); set_aux(0, 0, 0); q1_addr = 9;
        #3;
        chk("kill_waddr", 32'(grf_waddr), 32'd9);
        chk("kill_wdata", grf_wdata, 32'hB009);
        chk("kill_q1", 32'(q1_pending), 32'd1);
        next();
        set_wb(0, 0, 0);
        #3;
        chk("kill_rem", 32'(grf_waddr), 32'd7);
        chk("kill_pcnt", 32'(pending_cnt), 32'd1);
        chk("kill_q1b", 32'(q1_pending), 32'd0);
        next();
        #3;
        chk("kill_empty", 32'(grf_waddr), 32'd0);
        next();

        // Starvation forces a WB stall on the 5th cycle
        set_aux(1, 3, 32'h3333);
        next();
        set_aux(0, 0, 0); set_wb(1, 4, 32'h4444);
        for (int i = 0; i < 4; i++) begin
            #3;
            chk("starve_wb", 32'(grf_waddr), 32'd4);
            chk("starve_nostall", 32'(wb_stall), 32'd0);
            next();
        end
        #3;
        chk("starve_stall", 32'(wb_stall), 32'd1);
        chk("starve_waddr", 32'(grf_waddr), 32'd3);
        next();
        #3;
        chk("starve_resume", 32'(grf_waddr), 32'd4);
        chk("starve_empty", 32'(pending_cnt), 32'd0);
        next();

        // Same-register AUX dropped, zero-address AUX consumed
        set_wb(1, 6, 32'h6666); set_aux(1, 6, 32'h0606);
        next();
        set_wb(0, 0, 0); set_aux(1, 0, 32'h0);
        #3;
        chk("drop_waddr", 32'(grf_waddr), 32'd0);
        next();
        set_aux(0, 0, 0);
        #3;
        chk("zero_pcnt", 32'(pending_cnt), 32'd0);
        next();

        // Fill to two entries, third held off until the forced drain
        set_wb(1, 10, 32'hAAAA); set_aux(1, 11, 32'hB0B0_0011);
        next();
        set_aux(1, 12, 32'hB0B0_0012);
        next();
        set_aux(1, 13, 32'hB0B0_0013);
        #3;
        chk("full_ready", 32'(aux_ready), 32'd0);
        chk("full_pcnt", 32'(pending_cnt), 32'd2);
        next();
        next();
        next();
        #3;
        chk("full_stall", 32'(wb_stall), 32'd1);
        chk("full_head", 32'(grf_waddr), 32'd11);
        chk("full_noready", 32'(aux_ready), 32'd0);
        next();
        #3;
        chk("full_accept", 32'(aux_ready), 32'd1);
        next();
        set_wb(0, 0, 0); set_aux(0, 0, 0);
        #3;
        chk("order_12", 32'(grf_waddr), 32'd12);
        next();
        #3;
        chk("order_13", 32'(grf_waddr), 32'd13);
        chk("order_d13", grf_wdata, 32'hB0B0_0013);
        next();

        // Asynchronous reset mid-drain
        set_wb(1, 10, 32'hAAAA); set_aux(1, 20, 32'h20);
        next();
        set_aux(1, 21, 32'h21);
        next();
        set_wb(0, 0, 0); set_aux(0, 0, 0);
        #2;
        chk("mid_head", 32'(grf_waddr), 32'd20);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_waddr", 32'(grf_waddr), 32'd0);
        chk("mid_rst_pcnt", 32'(pending_cnt), 32'd0);
        chk("mid_rst_ready", 32'(aux_ready), 32'd0);
        next();
        rst_n = 1'b1;
        next();
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("post_rst_waddr", 32'(grf_waddr), 32'd0);
            chk("post_rst_pcnt", 32'(pending_cnt), 32'd0);
            next();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
